pipeline_front_control: RTL
===========================

Name: pipeline_front_control

Overview:
- Consumer of the stall/flush pair driven by the hazard unit.
- Owns the PC register and the IF/ID pipeline register, applies branch redirect, and drives the bubble that zeroes ID/EX control.
- Watches for runaway stalls and optionally counts stall/flush events.
- Sits between instruction memory (IF) and the decode stage (ID).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WATCHDOG_LIMIT, 8, consecutive stall cycles that raise stallTimeout; legal range 3..255.
- COUNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  from hazard unit: hold PC and IF/ID
- flush  in  1  from hazard unit: insert bubble into ID/EX
- branchTakenID  in  1  branch/jump resolved taken in ID
- branchTargetID  in  32  redirect target, word aligned
- instrIF  in  32  instruction fetched at pcIF
- pcIF  out  32  current fetch address
- instrID  out  32  IF/ID instruction
- pcPlus4ID  out  32  IF/ID PC+4
- validID  out  1  IF/ID holds a real instruction
- bubbleEX  out  1  zero ID/EX control this edge
- stallTimeout  out  1  sticky watchdog flag
- stallCycles  out  COUNT_W  stall-cycle count (feature only)
- flushCount  out  COUNT_W  redirect count (feature only)

Behaviour:
- Reset (async, rst_n=0): pcIF=RESET_PC; instrID=0 (NOP); pcPlus4ID=0; validID=0; stallTimeout=0; counters=0; watchdog count=0.
- Release is synchronous to the next rising edge. The first edge after release fetches at RESET_PC.
- bubbleEX = stall | flush, combinational. The external ID/EX register samples it on the same edge.
- Per-edge priority, evaluated in this order:
  1. stall=1: pcIF holds; instrID, pcPlus4ID and validID hold. branchTakenID is ignored because the branch is not yet resolved.
  2. stall=0, branchTakenID=1: pcIF<=branchTargetID; instrID<=0; validID<=0 (kills the wrong-path fetch); pcPlus4ID<=0.
  3. Otherwise: pcIF<=pcIF+4 (wraps modulo 2^32); instrID<=instrIF; pcPlus4ID<=pcIF+4; validID<=1.
- flush=1 with stall=0 only bubbles EX. PC and IF/ID advance normally.
- Latency: a taken branch in ID at edge N puts the target in pcIF after edge N. It costs exactly one killed slot.
- Low bits of branchTargetID: [1:0] are forced to 0 when loaded.
- Watchdog:
  - 8-bit consecutive-stall counter; increments on each edge with stall=1 and clears on stall=0.
  - Saturates at WATCHDOG_LIMIT.
  - Reaching WATCHDOG_LIMIT sets stallTimeout. It stays set until reset.
  - The pipeline keeps obeying stall after timeout; the flag is diagnostic only.
- States (implicit): RUN (stall=0), HOLD (stall=1), REDIRECT (the one cycle after a taken branch, validID=0). HOLD can follow REDIRECT directly.

Optional Feature:
- Macro FRONT_PERF_COUNTERS_EN.
- Defined:
  - stallCycles increments on every edge with stall=1.
  - flushCount increments on every taken redirect (priority 2).
  - Both saturate at all-ones and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000
  - PC_W = 32
  - PC_STEP = 4
  - default RESET_PC
- One natural sub-module, if_id_register: the instrID, pcPlus4ID and validID flops with hold/clear/load controls.
- PC, watchdog and counters stay in the top module.

Test Plan:
- Reset then 3 free-running edges, instrIF=32'h2008_0005 -> pcIF steps 0,4,8,C; instrID=32'h2008_0005; pcPlus4ID=8 after edge 2; validID=1; bubbleEX=0.
- Load-use, stall=flush=1 for 1 cycle at pcIF=8 -> pcIF stays 8, IF/ID unchanged, bubbleEX=1 that cycle; next edge pcIF=C.
- Branch after load: stall for 2 cycles, then branchTakenID=1, target 32'h40 -> pcIF=40 after the third edge; instrID=0; validID=0; flushCount=1 (feature on).
- stall=1 and branchTakenID=1 in the same cycle -> hold wins, pcIF unchanged, no redirect counted.
- stall held 8 cycles (WATCHDOG_LIMIT=8) -> stallTimeout=1 after the 8th edge and stays 1 after stall drops; stallCycles=8.
- rst_n dropped mid-stall at pcIF=0x100 -> outputs immediately reach reset values without a clock; pcIF=0 on release; stallTimeout cleared.

Source files
------------

// File: rtl/pipeline_front_control_pkg.sv
// Shared constants and types for the fetch-side pipeline control slice.
package pipeline_front_control_pkg;

    localparam int unsigned PC_W = 32;
    localparam int unsigned WD_W = 8;

    localparam logic [PC_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'b00,
        IFID_LOAD  = 2'b01,
        IFID_CLEAR = 2'b10
    } ifid_ctrl_e;

endpackage

// File: rtl/pipeline_front_control_if_id_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit with hold/clear/load control.
module if_id_register
    import pipeline_front_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  ifid_ctrl_e      ctrl_i,
    input  logic [PC_W-1:0] instr_i,
    input  logic [PC_W-1:0] pc_plus4_i,
    output logic [PC_W-1:0] instr_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [PC_W-1:0] instr_q;
    logic [PC_W-1:0] pc_plus4_q;
    logic            valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            unique case (ctrl_i)
                IFID_LOAD: begin
                    instr_q    <= instr_i;
                    pc_plus4_q <= pc_plus4_i;
                    valid_q    <= 1'b1;
                end
                IFID_CLEAR: begin
                    instr_q    <= NOP_INSTR;
                    pc_plus4_q <= '0;
                    valid_q    <= 1'b0;
                end
                default: begin
                    instr_q    <= instr_q;
                    pc_plus4_q <= pc_plus4_q;
                    valid_q    <= valid_q;
                end
            endcase
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/pipeline_front_control.sv
// Front-end control: PC register, IF/ID register, branch redirect, EX bubble and stall watchdog.
// Optional stall/flush performance counters are built when FRONT_PERF_COUNTERS_EN is defined.
module pipeline_front_control
    import pipeline_front_control_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned     WATCHDOG_LIMIT = 8,
    parameter int unsigned     COUNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branchTakenID,
    input  logic [PC_W-1:0]    branchTargetID,
    input  logic [PC_W-1:0]    instrIF,
    output logic [PC_W-1:0]    pcIF,
    output logic [PC_W-1:0]    instrID,
    output logic [PC_W-1:0]    pcPlus4ID,
    output logic               validID,
    output logic               bubbleEX,
    output logic               stallTimeout,
    output logic [COUNT_W-1:0] stallCycles,
    output logic [COUNT_W-1:0] flushCount
);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_LIMIT);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4;
    ifid_ctrl_e      ifid_ctrl;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    assign pc_plus4 = pc_q + PC_STEP;
    assign bubbleEX = stall | flush;

    // Stall outranks redirect: a branch seen during a stall is not yet resolved.
    always_comb begin
        pc_d      = pc_q;
        ifid_ctrl = IFID_HOLD;
        if (stall) begin
            pc_d      = pc_q;
            ifid_ctrl = IFID_HOLD;
        end else if (branchTakenID) begin
            pc_d      = branchTargetID & PC_ALIGN_MASK;
            ifid_ctrl = IFID_CLEAR;
        end else begin
            pc_d      = pc_plus4;
            ifid_ctrl = IFID_LOAD;
        end
    end

    always_comb begin
        wd_d = '0;
        if (stall) begin
            wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 8'd1;
        end
        timeout_d = timeout_q | (wd_d == WD_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    if_id_register u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_i     (ifid_ctrl),
        .instr_i    (instrIF),
        .pc_plus4_i (pc_plus4),
        .instr_o    (instrID),
        .pc_plus4_o (pcPlus4ID),
        .valid_o    (validID)
    );

    assign pcIF         = pc_q;
    assign stallTimeout = timeout_q;

`ifdef FRONT_PERF_COUNTERS_EN
    logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               redirect;

    assign redirect = ~stall & branchTakenID;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule
